// File: rtl/lstm_step_scheduler.sv
// lstm_step_scheduler: shares one lstm_unit among NUM_REQ requesters.
// A round-robin arbiter picks a requester. The FSM then issues one lstm_start
// per time step and waits for lstm_done, with a per-step timeout. It returns
// one response per accepted request. Every output comes straight from a
// register. Each output register is loaded with the value that belongs to the
// state being entered.
module lstm_step_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ-1:0]       req_clr,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     lstm_start,
    output logic [ID_W-1:0]          lstm_ctx,
    output logic [LEN_W-1:0]         lstm_step,
    output logic                     lstm_clr_state,
    input  logic                     lstm_done,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [1:0]               rsp_status,
    output logic [LEN_W-1:0]         rsp_steps,
    input  logic                     rsp_ready,
    output logic                     busy
);

    localparam logic [1:0] STATUS_OK       = 2'b00;
    localparam logic [1:0] STATUS_TIMEOUT  = 2'b01;
    localparam logic [1:0] STATUS_ZERO_LEN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [ID_W-1:0]    ptr_reg, ptr_next;
    logic [ID_W-1:0]    id_reg, id_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic               clr_reg, clr_next;
    logic [LEN_W-1:0]   step_reg, step_next;
    logic [TO_W-1:0]    cnt_reg, cnt_next;

    logic [NUM_REQ-1:0] req_ready_reg, req_ready_next;
    logic               lstm_start_reg, lstm_start_next;
    logic [ID_W-1:0]    lstm_ctx_reg, lstm_ctx_next;
    logic [LEN_W-1:0]   lstm_step_reg, lstm_step_next;
    logic               lstm_clr_state_reg, lstm_clr_state_next;
    logic               rsp_valid_reg, rsp_valid_next;
    logic [ID_W-1:0]    rsp_id_reg, rsp_id_next;
    logic [1:0]         rsp_status_reg, rsp_status_next;
    logic [LEN_W-1:0]   rsp_steps_reg, rsp_steps_next;
    logic               busy_reg, busy_next;

    // Per-requester length fields, and the request vector rotated so that
    // bit 0 is the requester the pointer currently favours.
    logic [LEN_W-1:0]   len_arr [NUM_REQ];
    logic [NUM_REQ-1:0] rot_valid;
    logic [ID_W-1:0]    grant_off;
    logic [ID_W-1:0]    grant_id;
    logic [LEN_W-1:0]   step_inc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign len_arr[gi]   = req_len[gi*LEN_W +: LEN_W];
            assign rot_valid[gi] = req_valid[ptr_reg + ID_W'(gi)];
        end
    endgenerate

    assign step_inc = step_reg + LEN_W'(1);

    // State and output registers. Reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            ptr_reg            <= '0;
            id_reg             <= '0;
            len_reg            <= '0;
            clr_reg            <= 1'b0;
            step_reg           <= '0;
            cnt_reg            <= '0;
            req_ready_reg      <= '0;
            lstm_start_reg     <= 1'b0;
            lstm_ctx_reg       <= '0;
            lstm_step_reg      <= '0;
            lstm_clr_state_reg <= 1'b0;
            rsp_valid_reg      <= 1'b0;
            rsp_id_reg         <= '0;
            rsp_status_reg     <= '0;
            rsp_steps_reg      <= '0;
            busy_reg           <= 1'b0;
        end else begin
            state_reg          <= state_next;
            ptr_reg            <= ptr_next;
            id_reg             <= id_next;
            len_reg            <= len_next;
            clr_reg            <= clr_next;
            step_reg           <= step_next;
            cnt_reg            <= cnt_next;
            req_ready_reg      <= req_ready_next;
            lstm_start_reg     <= lstm_start_next;
            lstm_ctx_reg       <= lstm_ctx_next;
            lstm_step_reg      <= lstm_step_next;
            lstm_clr_state_reg <= lstm_clr_state_next;
            rsp_valid_reg      <= rsp_valid_next;
            rsp_id_reg         <= rsp_id_next;
            rsp_status_reg     <= rsp_status_next;
            rsp_steps_reg      <= rsp_steps_next;
            busy_reg           <= busy_next;
        end
    end

    // Arbitration, next-state logic and output values for the state being entered.
    always_comb begin
        state_next          = state_reg;
        ptr_next            = ptr_reg;
        id_next             = id_reg;
        len_next            = len_reg;
        clr_next            = clr_reg;
        step_next           = step_reg;
        cnt_next            = cnt_reg;
        req_ready_next      = '0;
        lstm_start_next     = 1'b0;
        lstm_ctx_next       = lstm_ctx_reg;
        lstm_step_next      = lstm_step_reg;
        lstm_clr_state_next = 1'b0;
        rsp_valid_next      = rsp_valid_reg;
        rsp_id_next         = rsp_id_reg;
        rsp_status_next     = rsp_status_reg;
        rsp_steps_next      = rsp_steps_reg;

        // The lowest set bit of the rotated vector is the first requester
        // at or after the pointer.
        grant_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_valid[i]) begin
                grant_off = ID_W'(i);
            end
        end
        grant_id = ptr_reg + grant_off;

        case (state_reg)
            ST_IDLE: begin
                if (|req_valid) begin
                    id_next        = grant_id;
                    len_next       = len_arr[grant_id];
                    clr_next       = req_clr[grant_id];
                    ptr_next       = grant_id + ID_W'(1);
                    step_next      = '0;
                    req_ready_next = NUM_REQ'(1) << grant_id;
                    if (len_arr[grant_id] == '0) begin
                        state_next      = ST_RESP;
                        rsp_valid_next  = 1'b1;
                        rsp_id_next     = grant_id;
                        rsp_status_next = STATUS_ZERO_LEN;
                        rsp_steps_next  = '0;
                    end else begin
                        state_next          = ST_ISSUE;
                        lstm_start_next     = 1'b1;
                        lstm_ctx_next       = grant_id;
                        lstm_step_next      = '0;
                        lstm_clr_state_next = req_clr[grant_id];
                        cnt_next            = '0;
                    end
                end
            end
            ST_ISSUE: begin
                // The ISSUE cycle counts toward the timeout window. A done
                // pulse here is ignored.
                state_next = ST_WAIT;
                cnt_next   = cnt_reg + TO_W'(1);
            end
            ST_WAIT: begin
                if (lstm_done) begin
                    step_next = step_inc;
                    if (step_inc == len_reg) begin
                        state_next      = ST_RESP;
                        rsp_valid_next  = 1'b1;
                        rsp_id_next     = id_reg;
                        rsp_status_next = STATUS_OK;
                        rsp_steps_next  = len_reg;
                    end else begin
                        state_next          = ST_ISSUE;
                        lstm_start_next     = 1'b1;
                        lstm_ctx_next       = id_reg;
                        lstm_step_next      = step_inc;
                        lstm_clr_state_next = clr_reg && (step_inc == '0);
                        cnt_next            = '0;
                    end
                end else if (cnt_reg == TO_W'(TIMEOUT - 1)) begin
                    state_next      = ST_RESP;
                    rsp_valid_next  = 1'b1;
                    rsp_id_next     = id_reg;
                    rsp_status_next = STATUS_TIMEOUT;
                    rsp_steps_next  = step_reg;
                end else begin
                    cnt_next = cnt_reg + TO_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next      = ST_IDLE;
                    rsp_valid_next  = 1'b0;
                    rsp_id_next     = '0;
                    rsp_status_next = '0;
                    rsp_steps_next  = '0;
                    lstm_ctx_next   = '0;
                    lstm_step_next  = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    assign req_ready      = req_ready_reg;
    assign lstm_start     = lstm_start_reg;
    assign lstm_ctx       = lstm_ctx_reg;
    assign lstm_step      = lstm_step_reg;
    assign lstm_clr_state = lstm_clr_state_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_id         = rsp_id_reg;
    assign rsp_status     = rsp_status_reg;
    assign rsp_steps      = rsp_steps_reg;
    assign busy           = busy_reg;

endmodule
